// File: rtl/fpga_io_bank_ctrl.sv
// Fabric-side controller for a bank of pad cells: registered, isolation-gated output path
// and a synchronised, turnaround-blanked, glitch-filtered input path with sticky edge flags.
module fpga_io_bank_ctrl #(
  parameter int WIDTH  = 8,
  parameter int FILT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_isol_n,
  input  logic [WIDTH-1:0]  fab_out,
  input  logic [WIDTH-1:0]  fab_dir,
  output logic [WIDTH-1:0]  fpga_out,
  output logic [WIDTH-1:0]  fpga_dir,
  input  logic [WIDTH-1:0]  fpga_in,
  input  logic [FILT_W-1:0] filt_len,
  output logic [WIDTH-1:0]  fab_in,
  output logic [WIDTH-1:0]  rise_evt,
  output logic [WIDTH-1:0]  fall_evt,
  input  logic [WIDTH-1:0]  evt_clr
);

  logic              iso_meta_q, iso_meta_d;
  logic              iso_ok_q, iso_ok_d;
  logic [WIDTH-1:0]  in_meta_q, in_meta_d;
  logic [WIDTH-1:0]  sync_q, sync_d;
  logic [WIDTH-1:0]  fpga_out_q, fpga_out_d;
  logic [WIDTH-1:0]  fpga_dir_q, fpga_dir_d;
  logic [WIDTH-1:0]  fab_in_q, fab_in_d;
  logic [WIDTH-1:0]  rise_q, rise_d;
  logic [WIDTH-1:0]  fall_q, fall_d;
  logic [FILT_W-1:0] cnt_q [WIDTH];
  logic [FILT_W-1:0] cnt_d [WIDTH];
  logic [1:0]        blank_q [WIDTH];
  logic [1:0]        blank_d [WIDTH];
  logic [WIDTH-1:0]  filt_en;
  logic [FILT_W-1:0] filt_lim;

  always_comb begin
    iso_meta_d = io_isol_n;
    iso_ok_d   = iso_meta_q;
    in_meta_d  = fpga_in;
    sync_d     = in_meta_q;
    fpga_out_d = iso_ok_q ? fab_out : '0;
    fpga_dir_d = iso_ok_q ? fab_dir : '0;
    // A zero filter length behaves like length one: accept on the first differing edge.
    filt_lim   = (filt_len == '0) ? '0 : filt_len - FILT_W'(1);
    fab_in_d   = fab_in_q;
    rise_d     = rise_q & ~evt_clr;
    fall_d     = fall_q & ~evt_clr;
    filt_en    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i]   = cnt_q[i];
      blank_d[i] = blank_q[i];
      if (fpga_dir_q[i]) begin
        blank_d[i] = 2'd2;
      end else if (blank_q[i] != 2'd0) begin
        blank_d[i] = blank_q[i] - 2'd1;
      end
      filt_en[i] = !fpga_dir_q[i] && (blank_q[i] == 2'd0) && iso_ok_q;
      if (!filt_en[i] || (sync_q[i] == fab_in_q[i])) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == filt_lim) begin
        cnt_d[i]    = '0;
        fab_in_d[i] = sync_q[i];
        if (sync_q[i]) begin
          rise_d[i] = 1'b1;
        end else begin
          fall_d[i] = 1'b1;
        end
      end else begin
        cnt_d[i] = cnt_q[i] + FILT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iso_meta_q <= 1'b0;
      iso_ok_q   <= 1'b0;
      in_meta_q  <= '0;
      sync_q     <= '0;
      fpga_out_q <= '0;
      fpga_dir_q <= '0;
      fab_in_q   <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i]   <= '0;
        blank_q[i] <= '0;
      end
    end else begin
      iso_meta_q <= iso_meta_d;
      iso_ok_q   <= iso_ok_d;
      in_meta_q  <= in_meta_d;
      sync_q     <= sync_d;
      fpga_out_q <= fpga_out_d;
      fpga_dir_q <= fpga_dir_d;
      fab_in_q   <= fab_in_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i]   <= cnt_d[i];
        blank_q[i] <= blank_d[i];
      end
    end
  end

  assign fpga_out = fpga_out_q;
  assign fpga_dir = fpga_dir_q;
  assign fab_in   = fab_in_q;
  assign rise_evt = rise_q;
  assign fall_evt = fall_q;

endmodule

// File: doc/fpga_io_bank_ctrl.md
Name: fpga_io_bank_ctrl

Overview:
- Fabric-side controller for a bank of WIDTH embedded I/O pad cells. It sits between the FPGA fabric and the pad wrappers: it drives each pad's FPGA_OUT/FPGA_DIR and consumes each pad's FPGA_IN.
- Registers the output path and applies isolation gating.
- Synchronises and glitch-filters the input path, blanks the input path around direction turnaround, and produces sticky per-pin rise/fall event flags for the fabric.

Parameters:
- WIDTH, 8: number of pad cells in the bank.
- FILT_W, 4: width of the glitch-filter length and of the per-pin counters.

Ports:
- clk  input  1  bank clock.
- reset  input  1  asynchronous, active-high reset.
- io_isol_n  input  1  asynchronous isolation control, active-low; synchronised internally.
- fab_out  input  WIDTH  fabric output data per pin.
- fab_dir  input  WIDTH  fabric direction per pin; 1 = output, 0 = input.
- fpga_out  output  WIDTH  registered output data to the pad cells.
- fpga_dir  output  WIDTH  registered direction to the pad cells.
- fpga_in  input  WIDTH  pad input data; asynchronous to clk; forced to 0 by the pad while its dir = 1.
- filt_len  input  FILT_W  stable-cycle count required before an input change is accepted; quasi-static.
- fab_in  output  WIDTH  synchronised, filtered input value per pin.
- rise_evt  output  WIDTH  sticky flag: fab_in went 0->1.
- fall_evt  output  WIDTH  sticky flag: fab_in went 1->0.
- evt_clr  input  WIDTH  write-1-to-clear for both event flags of a pin; single-cycle pulse.

Behaviour:
- Clocking and reset
  - Single clock domain (clk). Reset is asynchronous and active-high.
  - All flops clear on reset, including during an active filter count or blanking window.
  - Reset values: fpga_out=0, fpga_dir=0, fab_in=0, rise_evt=0, fall_evt=0.
  - Internal state also clears: filter counters, blank counters, sync flops, and the isolation synchroniser. The bank is therefore isolated until 2 edges after reset deasserts.
- Isolation
  - io_isol_n passes through a 2-flop synchroniser to give iso_ok.
  - iso_ok=0: fpga_out and fpga_dir are loaded with 0 on every edge. Filters and events are frozen: counters hold 0, fab_in holds, no flag sets. evt_clr still clears flags.
- Output path
  - iso_ok=1: fpga_out <= fab_out and fpga_dir <= fab_dir on every edge. Latency is 1 cycle.
- Input sync
  - Per pin, 2-flop synchroniser gives s. An fpga_in level present before edge k appears on s after edge k+1.
- Blanking
  - Per pin, 2-bit counter blank.
  - At each edge: if fpga_dir[i]=1 (pre-edge value), blank<=2; else if blank>0, blank<=blank-1.
  - The pin's filter is enabled only when fpga_dir[i]=0, blank=0 and iso_ok=1.
  - When not enabled: counter <= 0, fab_in holds, no event.
  - Effect: after fpga_dir falls at edge e, the filter first evaluates at edge e+3, so the sync pipeline is flushed of the pad's forced 0.
- Glitch filter (enabled pins only)
  - L = max(filt_len, 1).
  - If s == fab_in: cnt <= 0.
  - Else if cnt == L-1: fab_in <= s, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A change on s is accepted after L consecutive differing edges. Any reversion before acceptance restarts the count.
  - End-to-end latency, pad change to fab_in: 1+L edges after first capture.
- Events
  - On the edge fab_in[i] changes, set rise_evt[i] (0->1) or fall_evt[i] (1->0).
  - Flags stay set until evt_clr[i]=1, which clears both flags of pin i.
  - A set and a clear on the same edge leave the flag set (set wins).
- Pin independence
  - Pins are fully independent; no shared state except iso_ok and filt_len.

Test Plan:
- Reset/isolation: assert reset mid-run with fab_dir=8'hFF, fab_out=8'hA5 -> all outputs 0 immediately. After release with io_isol_n=1 -> fpga_out=8'hA5, fpga_dir=8'hFF on the 3rd edge; earlier edges give 0.
- Filter accept: filt_len=3, fab_dir=0, pin0 fpga_in 0->1 before edge 0 -> fab_in[0]=1 and rise_evt[0]=1 after edge 4. Same test with filt_len=0 -> after edge 2.
- Glitch reject: filt_len=4, pin3 high for 3 cycles then low -> fab_in[3] stays 0, rise_evt[3] stays 0. A subsequent 4-cycle high pulse -> accepted, then falls after 4 low cycles, with rise_evt=1 and fall_evt=1.
- Turnaround blanking: pin2 fab_in=1, fab_dir[2] toggled 0->1->0 with the pad driving 0 while dir=1 and fpga_in=1 afterwards -> no fall_evt[2]; fab_in[2] stays 1 throughout.
- Event clear: evt_clr[5]=1 on the same edge fab_in[5] rises -> rise_evt[5]=1. evt_clr[5]=1 one cycle later -> 0.
- Mid-operation isolation: io_isol_n=0 while pin1 filter is counting -> fpga_dir=0 two edges later, counter cleared, no event. After restore, the full L-cycle count restarts.
